serial_addr_decoder_n: RTL and testbench
========================================

// Module: serial_addr_decoder_n
// PURPOSE
// Parametrised serial-bus address decoder for N targets with a mask/base map.
// Deserialises the LSB-first address phase, decodes it and holds the one-hot target select.
// Counts the data phase and releases the selection after DATA_BITS data bits.
// Flags unmapped addresses and reports transfer completion; sits between bus master and target mux.
// PARAMETERS
// ADDR_W     16                        address bits per address phase (4..32)
// N_TGT      4                         number of targets (1..16)
// DATA_BITS  8                         data bits per transfer before selection release (1..255)
// TGT_BASE   {16'hC000,16'h8000,16'h4000,16'h0000}  packed [N_TGT*ADDR_W]; slice i = base of target i
// TGT_MASK   {16'hF000,16'hF000,16'hC000,16'hF800}  packed [N_TGT*ADDR_W]; slice i = compare mask of target i
// SEL_W      localparam = max(1,$clog2(N_TGT))      width of sel
// PORTS
// clk                input   1       clock, rising edge
// rst_n              input   1       reset, asynchronous, active-low
// bus_data_in        input   1       serial bit
// bus_data_in_valid  input   1       bus_data_in is valid this cycle
// bus_mode           input   1       1 = data phase, 0 = address phase
// tgt_valid          output  N_TGT   one-hot held target select
// sel                output  SEL_W   binary index of the held target (0 when none)
// sel_valid          output  1       |tgt_valid
// addr_err           output  1       1-cycle pulse: decoded address matched no target
// txn_done           output  1       1-cycle pulse: DATA_BITS data bits completed
// BEHAVIOUR
// - Reset: all outputs 0, shift register 0, counters 0, FSM = IDLE.
// - Reset asserted mid-operation aborts immediately; no pulse is emitted.
// - FSM states: IDLE (no selection), ADDR (collecting), DATA (selection held).
// - Address bit = cycle with bus_mode=0 && valid; shift <= {bit, shift[ADDR_W-1:1]}; addr_cnt++.
// - First address bit from IDLE or DATA enters ADDR; data_cnt := 0.
// - Current selection stays held until the new decode result loads.
// - Cycles with valid=0 hold all state; no timeout.
// - On the ADDR_W-th address bit, decode {bit, shift[ADDR_W-1:1]}.
// - Target i matches when (addr & MASK_i) == (BASE_i & MASK_i).
// - Multiple matches: the lowest index wins; output stays one-hot.
// - Decode latency: the result appears 1 cycle after the edge that sampled the last address bit.
// - On match: tgt_valid[i]=1, sel=i, sel_valid=1; FSM -> DATA.
// - On no match: tgt_valid=0, sel=0, addr_err=1 for 1 cycle; FSM -> IDLE.
// - addr_cnt wraps to 0 after every full address.
// - Partial address aborted by a data bit (bus_mode=1 && valid while in ADDR):
//   addr_cnt := 0, that bit is ignored, FSM returns to DATA if a selection is held, else IDLE.
// - Data bit = bus_mode=1 && valid in DATA; data_cnt++ (width $clog2(DATA_BITS+1)).
// - Data bits in IDLE are ignored; no error.
// - On the DATA_BITS-th data bit: 1 cycle later tgt_valid/sel/sel_valid clear and txn_done pulses for 1 cycle.
//   FSM -> IDLE, data_cnt := 0.
// - bus_mode=0 with valid=0 in DATA: data_cnt holds.
// - Outputs are registered only; there is no combinational path from inputs to outputs.
// TESTING
// - Addr 0x0123 sent LSB-first, 16 valid bits -> 1 cycle after the last bit: tgt_valid=4'b0001, sel=0, sel_valid=1.
// - Addr 0x8ABC, then 8 data bits -> tgt_valid=4'b0100, sel=2.
//   1 cycle after the 8th data bit: tgt_valid=0 and txn_done=1 for exactly 1 cycle.
// - Addr 0x2000 (unmapped) -> addr_err=1 for 1 cycle, tgt_valid=0; following data bits are ignored with no txn_done.
// - Addr 0x4000 held, 3 data bits, then new addr 0xC001 -> target 1 held until decode, then tgt_valid=4'b1000, data_cnt restarted.
//   A further 8 data bits -> txn_done.
// - Valid gaps inside address and data phases plus 5 address bits then a data bit -> partial address discarded.
//   A subsequent full addr 0x0000 decodes to target 0.
// - rst_n low mid-DATA after 4 bits -> all outputs 0 asynchronously.
//   After release, addr 0x4001 + 8 data bits -> normal select and txn_done.

Source files
------------

// File: rtl/serial_addr_decoder_n.sv
// serial_addr_decoder_n: deserialises an LSB-first address, decodes it against a
// mask/base map into a held one-hot target select, and releases it after DATA_BITS data bits.
module serial_addr_decoder_n #(
   parameter int ADDR_W = 16,
   parameter int N_TGT = 4,
   parameter int DATA_BITS = 8,
   parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = {16'hC000, 16'h8000, 16'h4000, 16'h0000},
   parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = {16'hF000, 16'hF000, 16'hC000, 16'hF800},
   localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bus_data_in,
   input  logic             bus_data_in_valid,
   input  logic             bus_mode,
   output logic [N_TGT-1:0] tgt_valid,
   output logic [SEL_W-1:0] sel,
   output logic             sel_valid,
   output logic             addr_err,
   output logic             txn_done
);
   localparam int AC_W = $clog2(ADDR_W);
   localparam int DC_W = $clog2(DATA_BITS + 1);
   localparam logic [AC_W-1:0] AC_LAST = AC_W'(ADDR_W - 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t           r_state, w_state_nxt;
   logic [ADDR_W-2:0] r_shift;
   logic [AC_W-1:0]  r_addr_cnt;
   logic [DC_W-1:0]  r_data_cnt;
   logic [N_TGT-1:0] r_tgt_valid, w_tgt_nxt, w_onehot;
   logic [SEL_W-1:0] r_sel, w_sel_nxt, w_idx;
   logic             r_addr_err, r_txn_done, w_err_nxt, w_done_nxt;
   logic [ADDR_W-1:0] w_addr;
   logic             w_abit, w_dbit, w_alast, w_dlast, w_abort, w_match;

   // Only the upper ADDR_W-1 bits need storing: the last bit joins them on the decode cycle.
   assign w_abit  = bus_data_in_valid & ~bus_mode;
   assign w_dbit  = bus_data_in_valid & bus_mode;
   assign w_addr  = {bus_data_in, r_shift};
   assign w_alast = w_abit && (r_addr_cnt == AC_LAST);
   assign w_dlast = w_dbit && (r_state == DATA) && (r_data_cnt == DC_LAST);
   assign w_abort = w_dbit && (r_state == ADDR);

   // Priority match: scanning downward lets the lowest matching index win.
   always_comb begin
      w_match = 1'b0;
      w_idx   = '0;
      for (int i = N_TGT - 1; i >= 0; i--)
         if ((w_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) == (TGT_BASE[i*ADDR_W +: ADDR_W] & TGT_MASK[i*ADDR_W +: ADDR_W])) begin
            w_match = 1'b1;
            w_idx   = SEL_W'(i);
         end
      w_onehot = w_match ? (N_TGT'(1) << w_idx) : '0;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;

   // FSM next state: an aborted partial address falls back to whatever selection is still held.
   always_comb begin
      w_state_nxt = r_state;
      if (w_alast)      w_state_nxt = w_match ? DATA : IDLE;
      else if (w_abit)  w_state_nxt = ADDR;
      else if (w_abort) w_state_nxt = (|r_tgt_valid) ? DATA : IDLE;
      else if (w_dlast) w_state_nxt = IDLE;
   end

   // FSM outputs: next values of the registered selection and the one-cycle pulses.
   always_comb begin
      w_tgt_nxt  = w_alast ? w_onehot : w_dlast ? '0 : r_tgt_valid;
      w_sel_nxt  = w_alast ? w_idx : w_dlast ? '0 : r_sel;
      w_err_nxt  = w_alast & ~w_match;
      w_done_nxt = w_dlast;
   end

   // Registered outputs, shift register and bit counters.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tgt_valid <= '0;
         r_sel       <= '0;
         r_addr_err  <= 1'b0;
         r_txn_done  <= 1'b0;
         r_shift     <= '0;
         r_addr_cnt  <= '0;
         r_data_cnt  <= '0;
      end else begin
         r_tgt_valid <= w_tgt_nxt;
         r_sel       <= w_sel_nxt;
         r_addr_err  <= w_err_nxt;
         r_txn_done  <= w_done_nxt;
         if (w_abit) r_shift <= w_addr[ADDR_W-1:1];
         if (w_abit)       r_addr_cnt <= w_alast ? '0 : r_addr_cnt + 1'b1;
         else if (w_abort) r_addr_cnt <= '0;
         if ((w_abit && r_state != ADDR) || w_alast || w_dlast) r_data_cnt <= '0;
         else if (w_dbit && r_state == DATA)                     r_data_cnt <= r_data_cnt + 1'b1;
      end

   assign tgt_valid = r_tgt_valid;
   assign sel       = r_sel;
   assign sel_valid = |r_tgt_valid;
   assign addr_err  = r_addr_err;
   assign txn_done  = r_txn_done;
endmodule

// File: tb/tb_serial_addr_decoder_n.sv
// tb_serial_addr_decoder_n: directed and random transfers checked cycle by cycle against a behavioural model.
module tb_serial_addr_decoder_n;
   localparam int AW = 16;
   localparam int NT = 4;
   localparam int DB = 8;

   logic clk = 1'b0, rst_n = 1'b0;
   logic bus_data_in = 1'b0, bus_data_in_valid = 1'b0, bus_mode = 1'b0;
   logic [NT-1:0] tgt_valid;
   logic [1:0] sel;
   logic sel_valid, addr_err, txn_done;

   int n_chk = 0, n_pass = 0;

   // behavioural model state
   int m_tgt = -1, m_acnt = 0, m_dcnt = 0;
   bit m_in_addr = 0, m_err = 0, m_done = 0;
   logic [AW-1:0] m_acc = '0;
   logic [AW-1:0] bases [NT] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
   logic [AW-1:0] masks [NT] = '{16'hF800, 16'hC000, 16'hF000, 16'hF000};

   serial_addr_decoder_n dut (
      .clk(clk), .rst_n(rst_n), .bus_data_in(bus_data_in),
      .bus_data_in_valid(bus_data_in_valid), .bus_mode(bus_mode),
      .tgt_valid(tgt_valid), .sel(sel), .sel_valid(sel_valid),
      .addr_err(addr_err), .txn_done(txn_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int decode(input logic [AW-1:0] a);
      for (int i = 0; i < NT; i++)
         if ((a & masks[i]) == (bases[i] & masks[i])) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_tgt = -1; m_acnt = 0; m_dcnt = 0; m_in_addr = 0; m_err = 0; m_done = 0; m_acc = '0;
   endtask

   task automatic model_step(input bit v, input bit m, input bit b);
      m_err = 0;
      m_done = 0;
      if (v && !m) begin
         if (!m_in_addr) m_dcnt = 0;
         m_in_addr = 1;
         m_acc = m_acc | (AW'(b) << m_acnt);
         m_acnt++;
         if (m_acnt == AW) begin
            m_tgt = decode(m_acc);
            m_err = (m_tgt < 0);
            m_in_addr = 0; m_acnt = 0; m_acc = '0; m_dcnt = 0;
         end
      end else if (v && m) begin
         if (m_in_addr) begin
            m_in_addr = 0; m_acnt = 0; m_acc = '0;
         end else if (m_tgt >= 0) begin
            m_dcnt++;
            if (m_dcnt == DB) begin
               m_tgt = -1; m_done = 1; m_dcnt = 0;
            end
         end
      end
   endtask

   function automatic logic [31:0] exp_vec();
      logic [3:0] t;
      logic [1:0] s;
      t = (m_tgt >= 0) ? 4'(1 << m_tgt) : 4'd0;
      s = (m_tgt >= 0) ? 2'(m_tgt) : 2'd0;
      return {23'd0, t, s, 1'(m_tgt >= 0), m_err, m_done};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {23'd0, tgt_valid, sel, sel_valid, addr_err, txn_done};
   endfunction

   task automatic cycle(input bit v, input bit m, input bit b);
      bus_data_in_valid = v;
      bus_mode = m;
      bus_data_in = b;
      @(posedge clk);
      model_step(v, m, b);
      #1 check("out", dut_vec(), exp_vec());
   endtask

   task automatic gap();
      cycle(1'b0, 1'($urandom % 2), 1'($urandom % 2));
   endtask

   task automatic send_addr(input logic [AW-1:0] a, input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && ($urandom % 3 == 0)) gap();
         cycle(1'b1, 1'b0, a[k]);
      end
   endtask

   task automatic send_data(input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && ($urandom % 3 == 0)) gap();
         cycle(1'b1, 1'b1, 1'($urandom % 2));
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("reset", dut_vec(), 32'd0);
      rst_n = 1'b1;
      // mapped address to target 0
      send_addr(16'h0123, AW, 0);
      check("t0123_tgt", tgt_valid, 4'b0001);
      check("t0123_sel", sel, 2'd0);
      check("t0123_sv", sel_valid, 1'b1);
      send_data(DB, 0);
      // full transfer to target 2 with exact txn_done timing
      send_addr(16'h8ABC, AW, 0);
      check("t8abc_tgt", tgt_valid, 4'b0100);
      check("t8abc_sel", sel, 2'd2);
      send_data(DB - 1, 0);
      check("t8abc_early", txn_done, 1'b0);
      send_data(1, 0);
      check("t8abc_done", txn_done, 1'b1);
      check("t8abc_rel", tgt_valid, 4'b0000);
      cycle(1'b0, 1'b0, 1'b0);
      check("t8abc_pulse", txn_done, 1'b0);
      // unmapped address
      send_addr(16'h2000, AW, 0);
      check("t2000_err", addr_err, 1'b1);
      check("t2000_tgt", tgt_valid, 4'b0000);
      cycle(1'b0, 1'b0, 1'b0);
      check("t2000_pulse", addr_err, 1'b0);
      send_data(DB, 0);
      check("t2000_nodone", txn_done, 1'b0);
      // reselect mid-transfer: old target held until decode, data count restarts
      send_addr(16'h4000, AW, 0);
      send_data(3, 0);
      send_addr(16'hC001, AW - 1, 0);
      check("tc001_hold", tgt_valid, 4'b0010);
      cycle(1'b1, 1'b0, 1'b1);
      check("tc001_tgt", tgt_valid, 4'b1000);
      send_data(DB - 1, 0);
      check("tc001_early", txn_done, 1'b0);
      send_data(1, 0);
      check("tc001_done", txn_done, 1'b1);
      // gaps plus an aborted partial address
      send_addr(16'h8000, AW, 1);
      send_data(3, 1);
      send_addr(16'hFFFF, 5, 0);
      cycle(1'b1, 1'b1, 1'b0);
      check("abort_hold", tgt_valid, 4'b0100);
      send_addr(16'h0000, AW, 1);
      check("t0000_tgt", tgt_valid, 4'b0001);
      send_data(DB, 1);
      // asynchronous reset mid-data
      send_addr(16'h4000, AW, 0);
      send_data(4, 0);
      bus_data_in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 check("async_rst", dut_vec(), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      send_addr(16'h4001, AW, 0);
      check("t4001_tgt", tgt_valid, 4'b0010);
      send_data(DB, 0);
      check("t4001_done", txn_done, 1'b1);
      // random transfers
      repeat (80) begin
         logic [AW-1:0] a;
         a = AW'($urandom);
         if ($urandom % 4 == 0) a = bases[$urandom % NT] | (a & 16'h07FF);
         if ($urandom % 6 == 0) send_addr(a, int'($urandom_range(1, AW - 1)), 1);
         else send_addr(a, AW, 1);
         send_data(int'($urandom_range(0, DB + 3)), 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
